// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte port between NUM_CH packet sources.
// Optional per-grant channel-ID header byte enabled by defining UART_ARB_CH_ID_EN.
module uart_tx_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_data,
    input  logic [NUM_CH-1:0]            i_ch_valid,
    input  logic [NUM_CH-1:0]            i_ch_last,
    output logic [NUM_CH-1:0]            o_ch_ready,
    output logic [DATA_WIDTH-1:0]        o_tx_data,
    output logic                         o_tx_valid,
    input  logic                         i_tx_ready,
    output logic [NUM_CH-1:0]            o_grant,
    output logic                         o_busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(NUM_CH - 1);

`ifdef UART_ARB_CH_ID_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ID = 2'd1, S_XFER = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd2} state_t;
`endif

    state_t                  r_state;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_gIdx;
    logic [CNT_W-1:0]        r_burstCnt;

    logic [IDX_W-1:0]        w_selIdx;
    logic                    w_selFound;
    logic                    w_gValid;
    logic                    w_gLast;
    logic [DATA_WIDTH-1:0]   w_gData;
    logic                    w_stageFree;
    logic                    w_xferReady;
    logic                    w_chFire;
    logic                    w_pktEnd;

    // First requesting channel strictly after the last-served pointer, wrapping around.
    always_comb begin
        w_selIdx   = '0;
        w_selFound = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!w_selFound && i_ch_valid[(int'(r_ptr) + i) % NUM_CH]) begin
                w_selFound = 1'b1;
                w_selIdx   = IDX_W'((int'(r_ptr) + i) % NUM_CH);
            end
        end
    end

    assign w_gValid    = i_ch_valid[r_gIdx];
    assign w_gLast     = i_ch_last[r_gIdx];
    assign w_gData     = i_ch_data[r_gIdx*DATA_WIDTH +: DATA_WIDTH];
    assign w_stageFree = !o_tx_valid || i_tx_ready;
    assign w_xferReady = (r_state == S_XFER) && w_stageFree;
    assign w_chFire    = w_xferReady && w_gValid;
    assign w_pktEnd    = w_gLast || (r_burstCnt == BURST_END);

    assign o_ch_ready  = w_xferReady ? o_grant : '0;
    assign o_busy      = (r_state != S_IDLE) || o_tx_valid;

`ifdef UART_ARB_CH_ID_EN
    logic [DATA_WIDTH-1:0] w_hdr;
    assign w_hdr = DATA_WIDTH'({4'hA, 4'(r_gIdx)});
`endif

    // Grant FSM plus the one-entry output stage; a drain and a reload in the same
    // cycle keep o_tx_valid high so consecutive bytes have no bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= PTR_INIT;
            r_gIdx     <= '0;
            r_burstCnt <= '0;
            o_grant    <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            if (o_tx_valid && i_tx_ready) begin
                o_tx_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_selFound) begin
                        o_grant    <= NUM_CH'(1) << w_selIdx;
                        r_gIdx     <= w_selIdx;
                        r_burstCnt <= '0;
`ifdef UART_ARB_CH_ID_EN
                        r_state    <= S_ID;
`else
                        r_state    <= S_XFER;
`endif
                    end
                end
`ifdef UART_ARB_CH_ID_EN
                S_ID: begin
                    if (w_stageFree) begin
                        o_tx_data  <= w_hdr;
                        o_tx_valid <= 1'b1;
                        r_state    <= S_XFER;
                    end
                end
`endif
                S_XFER: begin
                    if (w_chFire) begin
                        o_tx_data  <= w_gData;
                        o_tx_valid <= 1'b1;
                        r_burstCnt <= r_burstCnt + 1'b1;
                        if (w_pktEnd) begin
                            r_ptr   <= r_gIdx;
                            o_grant <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: packet-level reference model checked every
// cycle, directed scenarios with literal byte-order expectations, then random traffic.
module tb_uart_tx_arbiter;

    localparam int NUM_CH = 4;
    localparam int DW     = 8;
    localparam int MB     = 4;
`ifdef UART_ARB_CH_ID_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_CH*DW-1:0]   chData;
    logic [NUM_CH-1:0]      chValid;
    logic [NUM_CH-1:0]      chLast;
    logic [NUM_CH-1:0]      chReady;
    logic [DW-1:0]          txData;
    logic                   txValid;
    logic                   txReady;
    logic [NUM_CH-1:0]      grant;
    logic                   busy;

    logic                   readyCtl;
    logic                   randMode;
    logic [NUM_CH-1:0]      holdOff;
    logic [8:0]             srcQ[NUM_CH][$];
    logic [7:0]             logQ[$];
    logic [7:0]             expQ[$];

    int nAsserts = 0;
    int nFail    = 0;

    // Reference model: who owns the port, bytes sent in this grant, last served
    // channel, pending header, and the single-byte output slot.
    int         mOwner;
    int         mPrev;
    int         mSent;
    bit         mHdr;
    bit         mFull;
    logic [7:0] mData;

    uart_tx_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ch_data  (chData),
        .i_ch_valid (chValid),
        .i_ch_last  (chLast),
        .o_ch_ready (chReady),
        .o_tx_data  (txData),
        .o_tx_valid (txValid),
        .i_tx_ready (txReady),
        .o_grant    (grant),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mOwner = -1;
        mPrev  = NUM_CH - 1;
        mSent  = 0;
        mHdr   = 1'b0;
        mFull  = 1'b0;
        mData  = 8'h00;
    endtask

    task automatic modelStep();
        bit canLoad;
        bit found;
        canLoad = !mFull || txReady;
        found   = 1'b0;
        if (mFull && txReady) mFull = 1'b0;
        if (mOwner < 0) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                int c;
                c = (mPrev + i) % NUM_CH;
                if (!found && chValid[c]) begin
                    found  = 1'b1;
                    mOwner = c;
                    mSent  = 0;
                    mHdr   = ID_EN;
                end
            end
        end else if (mHdr) begin
            if (canLoad) begin
                mData = {4'hA, 4'(mOwner)};
                mFull = 1'b1;
                mHdr  = 1'b0;
            end
        end else if (canLoad && chValid[mOwner]) begin
            mData = chData[mOwner*DW +: DW];
            mFull = 1'b1;
            mSent++;
            if (chLast[mOwner] || mSent == MB) begin
                mPrev  = mOwner;
                mOwner = -1;
            end
        end
    endtask

    // Sources advance one byte per accepted handshake; the rest is randomised noise.
    always @(posedge clk) begin
        #1;
        if (randMode) begin
            txReady = ($urandom_range(0, 9) < 7);
            holdOff = NUM_CH'($urandom) & NUM_CH'($urandom);
        end else begin
            txReady = readyCtl;
            holdOff = '0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (srcQ[k].size() > 0 && !holdOff[k]) begin
                chValid[k]          = 1'b1;
                chData[k*DW +: DW]  = srcQ[k][0][7:0];
                chLast[k]           = srcQ[k][0][8];
            end else begin
                chValid[k]          = 1'b0;
                chLast[k]           = 1'($urandom);
                chData[k*DW +: DW]  = 8'($urandom);
            end
        end
    end

    // Single compare process: outputs against the model, then advance to the next edge.
    always @(negedge clk) begin
        logic [NUM_CH-1:0] expGrant;
        logic [NUM_CH-1:0] expReady;
        if (rst) modelReset();
        expGrant = (mOwner >= 0) ? NUM_CH'(1) << mOwner : '0;
        expReady = (mOwner >= 0 && !mHdr && (!mFull || txReady)) ? expGrant : '0;
        checkOutput("cyc_grant",    32'(grant),   32'(expGrant));
        checkOutput("cyc_ch_ready", 32'(chReady), 32'(expReady));
        checkOutput("cyc_tx_valid", 32'(txValid), 32'(mFull));
        checkOutput("cyc_tx_data",  32'(txData),  32'(mData));
        checkOutput("cyc_busy",     32'(busy),    32'((mOwner >= 0) || mFull));
        if (!rst) begin
            if (txValid && txReady) logQ.push_back(txData);
            for (int k = 0; k < NUM_CH; k++) begin
                if (chReady[k] && chValid[k] && srcQ[k].size() > 0) void'(srcQ[k].pop_front());
            end
            modelStep();
        end
    end

    task automatic applyStimulus(input int ch, input logic [7:0] data, input logic last);
        srcQ[ch].push_back({last, data});
    endtask

    task automatic expHdr(input int ch);
        if (ID_EN) expQ.push_back({4'hA, 4'(ch)});
    endtask

    task automatic checkLog(input string name);
        checkOutput({name, "_count"}, 32'(logQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", name, i),
                        (i < logQ.size()) ? 32'(logQ[i]) : 32'hFFFF_FFFF, 32'(expQ[i]));
        end
        logQ.delete();
        expQ.delete();
    endtask

    task automatic waitIdle(input string name, input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = !busy && srcQ[0].size() == 0 && srcQ[1].size() == 0 &&
                   srcQ[2].size() == 0 && srcQ[3].size() == 0;
        end
        checkOutput({name, "_idle"}, 32'(done), 32'd1);
    endtask

    task automatic applyReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_tx_valid", 32'(txValid), 32'd0);
        checkOutput("rst_tx_data",  32'(txData),  32'd0);
        checkOutput("rst_grant",    32'(grant),   32'd0);
        checkOutput("rst_ch_ready", 32'(chReady), 32'd0);
        checkOutput("rst_busy",     32'(busy),    32'd0);
        for (int k = 0; k < NUM_CH; k++) srcQ[k].delete();
        logQ.delete();
        expQ.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        readyCtl = 1'b1;
        randMode = 1'b0;
        holdOff  = '0;
        chValid  = '0;
        chLast   = '0;
        chData   = '0;
        txReady  = 1'b1;
        modelReset();
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_tx_valid", 32'(txValid), 32'd0);
        checkOutput("reset_grant",    32'(grant),   32'd0);
        checkOutput("reset_busy",     32'(busy),    32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] single channel");
        @(posedge clk);
        #2;
        applyStimulus(0, 8'h11, 1'b0);
        applyStimulus(0, 8'h22, 1'b0);
        applyStimulus(0, 8'h33, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("single_grant_n1", 32'(grant),   32'h1);
        checkOutput("single_valid_n1", 32'(txValid), 32'd0);
        @(negedge clk);
        checkOutput("single_valid_n2", 32'(txValid), 32'd1);
        checkOutput("single_data_n2",  32'(txData),  ID_EN ? 32'hA0 : 32'h11);
        waitIdle("single", 40);
        checkOutput("single_grant_end", 32'(grant), 32'h0);
        expHdr(0);
        expQ.push_back(8'h11);
        expQ.push_back(8'h22);
        expQ.push_back(8'h33);
        checkLog("single");

        $display("[TB] round robin");
        applyReset();
        for (int k = 0; k < NUM_CH; k++) begin
            applyStimulus(k, 8'(8'hA0 + k), 1'b1);
            expHdr(k);
            expQ.push_back(8'(8'hA0 + k));
        end
        waitIdle("rr4", 60);
        checkLog("rr4");
        applyStimulus(1, 8'hA1, 1'b1);
        applyStimulus(3, 8'hA3, 1'b1);
        expHdr(1);
        expQ.push_back(8'hA1);
        expHdr(3);
        expQ.push_back(8'hA3);
        waitIdle("rr2", 40);
        checkLog("rr2");

        $display("[TB] backpressure");
        readyCtl = 1'b0;
        applyStimulus(2, 8'h5A, 1'b0);
        applyStimulus(2, 8'h5B, 1'b1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(txValid), 32'd1);
            checkOutput("bp_data",  32'(txData),  ID_EN ? 32'hA2 : 32'h5A);
            checkOutput("bp_ready", 32'(chReady), 32'd0);
        end
        readyCtl = 1'b1;
        waitIdle("bp", 40);
        expHdr(2);
        expQ.push_back(8'h5A);
        expQ.push_back(8'h5B);
        checkLog("bp");

        $display("[TB] burst limit");
        @(posedge clk);
        #2;
        for (int i = 0; i < 6; i++) applyStimulus(1, 8'(8'hB0 + i), 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("burst_grant_ch1", 32'(grant), 32'h2);
        applyStimulus(3, 8'hC3, 1'b1);
        repeat (30) @(negedge clk);
        expHdr(1);
        for (int i = 0; i < 4; i++) expQ.push_back(8'(8'hB0 + i));
        expHdr(3);
        expQ.push_back(8'hC3);
        expHdr(1);
        expQ.push_back(8'hB4);
        expQ.push_back(8'hB5);
        checkLog("burst");
        checkOutput("burst_locked", 32'(grant), 32'h2);

        $display("[TB] packet lock and reset");
        applyReset();
        applyStimulus(0, 8'hD0, 1'b0);
        applyStimulus(0, 8'hD1, 1'b0);
        applyStimulus(1, 8'hE0, 1'b1);
        repeat (15) @(negedge clk);
        checkOutput("lock_grant", 32'(grant), 32'h1);
        checkOutput("lock_busy",  32'(busy),  32'd1);
        expHdr(0);
        expQ.push_back(8'hD0);
        expQ.push_back(8'hD1);
        checkLog("lock");
        readyCtl = 1'b0;
        applyStimulus(0, 8'hD2, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("lock_buffered_valid", 32'(txValid), 32'd1);
        checkOutput("lock_buffered_data",  32'(txData),  32'hD2);
        applyReset();
        readyCtl = 1'b1;
        applyStimulus(1, 8'hE1, 1'b1);
        applyStimulus(0, 8'hF0, 1'b1);
        expHdr(0);
        expQ.push_back(8'hF0);
        expHdr(1);
        expQ.push_back(8'hE1);
        waitIdle("post_reset", 40);
        checkLog("post_reset");

        $display("[TB] random traffic");
        randMode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            for (int k = 0; k < NUM_CH; k++) begin
                if (srcQ[k].size() == 0 && $urandom_range(0, 7) == 0) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) applyStimulus(k, 8'($urandom), b == len - 1);
                end
            end
        end
        randMode = 1'b0;
        waitIdle("random", 500);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_CH byte-stream requesters.
- Sits between the channel sources and the UART TX valid/ready byte port.
- Grants one channel at a time and holds the grant for a whole packet (until last, or until a burst limit is reached).
- Forwards bytes through a one-entry registered output stage.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- DATA_WIDTH, 8, byte width; equals UART data width.
- MAX_BURST, 16, maximum bytes per grant before forced re-arbitration (1..255).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_ch_data  input  NUM_CH*DATA_WIDTH  channel k byte at [k*DATA_WIDTH +: DATA_WIDTH]
- i_ch_valid  input  NUM_CH  per-channel byte valid
- i_ch_last  input  NUM_CH  per-channel end-of-packet, qualified by valid
- o_ch_ready  output  NUM_CH  per-channel accept; at most one bit high
- o_tx_data  output  DATA_WIDTH  byte to UART TX
- o_tx_valid  output  1  byte valid to UART TX
- i_tx_ready  input  1  UART TX ready
- o_grant  output  NUM_CH  one-hot current grant, 0 when idle
- o_busy  output  1  high while a grant is active or o_tx_valid is high

Behaviour:
- Reset values: o_tx_valid=0, o_tx_data=0, o_grant=0, o_ch_ready=0, o_busy=0. Internal state: state=IDLE, burst count=0, rotation pointer=NUM_CH-1 (so ch0 has first priority).
- Reset mid-operation: all state clears immediately; the buffered byte is dropped.
- State IDLE: o_grant=0.
  - If any i_ch_valid bit is set, select the first set channel searching upward from pointer+1, with wrap.
  - Register the selection into o_grant, clear the burst count, go to XFER.
  - Arbitration latency: valid at edge n gives grant at n+1 and the earliest o_tx_valid at n+2.
- State XFER: o_ch_ready[g] = grant[g] & (!o_tx_valid | i_tx_ready). This is combinational from the registered grant and i_tx_ready.
- Channel handshake (valid&ready on the granted channel):
  - Load o_tx_data and set o_tx_valid on the next edge.
  - Burst count increments.
- Downstream handshake (o_tx_valid & i_tx_ready) with no new load: o_tx_valid clears on the next edge.
- A load and a downstream handshake in the same cycle give back-to-back bytes with no bubble.
- o_tx_data holds stable while o_tx_valid=1 and i_tx_ready=0.
- Packet end:
  - A handshake with i_ch_last=1, or with burst count reaching MAX_BURST-1, ends the grant.
  - Pointer takes the granted index; o_grant clears; go to IDLE.
  - The buffered byte still drains after the grant clears.
  - If last and the burst limit coincide, exactly one re-arbitration occurs.
- Granted channel deasserts valid mid-packet: the grant is held (packet lock) indefinitely; other channels wait.
- Valid bits of non-granted channels are ignored. o_ch_ready is never high for a non-granted channel.
- Burst counter width: clog2(MAX_BURST+1); it never wraps, since it clears on grant.
- o_busy = (state!=IDLE) | o_tx_valid.

Optional Feature:
- Macro: UART_ARB_CH_ID_EN.
- When defined, XFER is preceded by state ID.
  - The first byte emitted for each grant is a header {4'hA, channel index zero-extended to 4 bits} (DATA_WIDTH=8 only).
  - o_ch_ready stays 0 during ID.
  - ID exits to XFER after that header is loaded into the output stage.
  - The header does not count toward MAX_BURST.
- When undefined: no ID state, no header bytes; IDLE goes directly to XFER.

Test Plan:
- Single channel: ch0 sends 3 bytes 0x11,0x22,0x33 with last on 0x33, i_tx_ready held 1. Response: o_tx_data sequence 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first valid; o_grant=0001 then 0000; o_busy falls after the last drain.
- Round robin: ch0..ch3 each present one last-flagged byte (0xA0+k) simultaneously. Response: output order 0xA0,0xA1,0xA2,0xA3. Repeat with ch1 and ch3 only: order 0xA1,0xA3.
- Backpressure: i_tx_ready=0 for 10 cycles while ch2 holds valid with 0x5A. Response: o_tx_data=0x5A stable, o_tx_valid=1, o_ch_ready=0; exactly one byte transferred when ready returns.
- Burst limit: MAX_BURST=4, ch1 streams 6 bytes without last while ch3 is waiting. Response: 4 ch1 bytes, then ch3's packet, then the remaining 2 ch1 bytes.
- Packet lock and reset: ch0 drops valid mid-packet while ch1 is valid. Response: grant stays 0001 with no ch1 output. Then assert i_rst for 1 cycle mid-packet. Response: all outputs return to reset values immediately; ch0 is granted first afterwards.
- UART_ARB_CH_ID_EN defined: ch2 sends one byte 0x7E with last. Response: o_tx_data 0xA2 then 0x7E.
